dist_pkt_fifo: RTL and testbench

Single-clock packet FIFO built on distributed (LUT) SDPRAM, the parametrised successor to the plain distributed SDPRAM used in the packet-data path. Adds commit/rollback packet semantics, stored end-of-packet marker, full/empty/almost flags, occupancy and packet counters, and selectable FWFT or registered read mode. Sits between the packet assembler (write side) and the packet transmitter (read side), both on `wr_clk`.

---
 rtl/dist_pkt_fifo_if.sv | 35 +++
 rtl/dist_pkt_fifo.sv | 108 ++++++++++
 tb/tb_dist_pkt_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_pkt_fifo_if.sv
// Write/read handshake and status bundle of the packet FIFO.
// master = assembler/transmitter side, slave = the FIFO itself.
interface dist_pkt_fifo_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_drop;
  logic                  full;
  logic                  almost_full;
  logic                  wr_overflow;
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [ADDR_WIDTH:0]   pkt_cnt;

  modport master (
    output wr_en, wr_data, wr_last, wr_drop, rd_en,
    input  full, almost_full, wr_overflow, wr_cnt,
    input  rd_data, rd_last, rd_valid, empty, almost_empty, rd_cnt, pkt_cnt
  );

  modport slave (
    input  wr_en, wr_data, wr_last, wr_drop, rd_en,
    output full, almost_full, wr_overflow, wr_cnt,
    output rd_data, rd_last, rd_valid, empty, almost_empty, rd_cnt, pkt_cnt
  );
endinterface

// File: rtl/dist_pkt_fifo.sv
// Single-clock packet FIFO on distributed RAM with commit/rollback,
// stored end-of-packet bit and FWFT or registered read port.
module dist_pkt_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit OUT_REG    = 1'b0,
  parameter int AF_TH      = 2**ADDR_WIDTH - 2,
  parameter int AE_TH      = 2
) (
  input logic            wr_clk,
  input logic            asyn_rst,
  dist_pkt_fifo_if.slave bus
);
  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH  = ptr_t'(2**ADDR_WIDTH);
  localparam ptr_t AF_LIM = ptr_t'(AF_TH);
  localparam ptr_t AE_LIM = ptr_t'(AE_TH);
  localparam ptr_t ONE    = ptr_t'(1);

  logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH:0] rd_word;

  ptr_t wr_ptr, cmt_ptr, rd_ptr, pkt_cnt;
  ptr_t wr_cnt, rd_cnt;
  logic err, overflow;
  logic full, empty;
  logic rollback, wr_acc, commit, rd_acc, last_rd;

  assign wr_cnt = wr_ptr - rd_ptr;
  assign rd_cnt = cmt_ptr - rd_ptr;
  assign full   = (wr_cnt == DEPTH);
  assign empty  = (rd_ptr == cmt_ptr);

  // A closing word that cannot be stored (or follows a lost word) kills the
  // whole open packet instead of committing a truncated one.
  assign rollback = bus.wr_drop | (bus.wr_en & bus.wr_last & (err | full));
  assign wr_acc   = bus.wr_en & ~full & ~rollback;
  assign commit   = wr_acc & bus.wr_last & ~err;
  assign rd_acc   = bus.rd_en & ~empty;
  assign rd_word  = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign last_rd  = rd_acc & rd_word[DATA_WIDTH];

  always_ff @(posedge wr_clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (rollback) begin
        wr_ptr <= cmt_ptr;
        err    <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + ONE;
        if (commit) cmt_ptr <= wr_ptr + ONE;
        if (bus.wr_en && full) err <= 1'b1;
      end
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (commit && !last_rd)      pkt_cnt <= pkt_cnt + ONE;
      else if (!commit && last_rd) pkt_cnt <= pkt_cnt - ONE;
      overflow <= bus.wr_en & full;
    end
  end

  assign bus.full         = full;
  assign bus.almost_full  = (wr_cnt >= AF_LIM);
  assign bus.wr_overflow  = overflow;
  assign bus.wr_cnt       = wr_cnt;
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_cnt <= AE_LIM);
  assign bus.rd_cnt       = rd_cnt;
  assign bus.pkt_cnt      = pkt_cnt;

  if (OUT_REG) begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  valid_q;

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
        data_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          data_q <= rd_word[DATA_WIDTH-1:0];
          last_q <= rd_word[DATA_WIDTH];
        end
      end
    end

    assign bus.rd_data  = data_q;
    assign bus.rd_last  = last_q;
    assign bus.rd_valid = valid_q;
  end else begin : g_fwft
    assign bus.rd_data  = rd_word[DATA_WIDTH-1:0];
    assign bus.rd_last  = rd_word[DATA_WIDTH];
    assign bus.rd_valid = ~empty;
  end
endmodule

// File: tb/tb_dist_pkt_fifo.sv
// Scoreboard bench: FWFT instance for packet semantics, registered-read
// instance for latency and pointer wrap.
module tb_dist_pkt_fifo;
  logic wr_clk = 1'b0;
  logic asyn_rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 wr_clk = ~wr_clk;

  dist_pkt_fifo_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if0 ();
  dist_pkt_fifo_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) if1 ();

  dist_pkt_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(1'b0)) u0 (
    .wr_clk(wr_clk), .asyn_rst(asyn_rst), .bus(if0.slave));
  dist_pkt_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(1'b1)) u1 (
    .wr_clk(wr_clk), .asyn_rst(asyn_rst), .bus(if1.slave));

  // reference model of the FWFT instance
  logic [8:0] exp_q[$];
  logic [8:0] open_q[$];
  logic [8:0] exp1_q[$];
  bit merr = 0;
  int mpkt = 0;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    open_q.delete();
    exp1_q.delete();
    merr = 0;
    mpkt = 0;
  endtask

  task automatic step0(input logic we, input logic [7:0] d, input logic l,
                       input logic drop, input logic rd);
    logic [8:0] w;
    bit full_m, rb;
    full_m = (exp_q.size() + open_q.size()) == 16;
    if (rd && exp_q.size() > 0) begin
      checks++;
      if ({if0.rd_last, if0.rd_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL rd_word0 got %h expected %h", {if0.rd_last, if0.rd_data}, exp_q[0]);
      end
    end
    if0.wr_en = we; if0.wr_data = d; if0.wr_last = l; if0.wr_drop = drop; if0.rd_en = rd;
    tick();
    if0.wr_en = 0; if0.wr_last = 0; if0.wr_drop = 0; if0.rd_en = 0;
    if (rd && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (w[8]) mpkt--;
    end
    rb = drop || (we && l && (merr || full_m));
    if (rb) begin
      open_q.delete();
      merr = 0;
    end else if (we && !full_m) begin
      open_q.push_back({l, d});
      if (l) begin
        foreach (open_q[i]) exp_q.push_back(open_q[i]);
        open_q.delete();
        mpkt++;
      end
    end else if (we) begin
      merr = 1;
    end
  endtask

  task automatic test_reset();
    asyn_rst = 1;
    repeat (2) tick();
    checks++;
    if ({if0.empty, if0.almost_empty, if0.full, if0.almost_full, if0.wr_overflow} !== 5'b11000) begin
      errors++; $display("FAIL reset_flags0 got %b expected 11000",
        {if0.empty, if0.almost_empty, if0.full, if0.almost_full, if0.wr_overflow});
    end
    checks++;
    if ({if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt} !== 15'd0) begin
      errors++; $display("FAIL reset_cnt0 got %h expected 0", {if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt});
    end
    checks++;
    if ({if1.rd_valid, if1.rd_last, if1.rd_data} !== 10'd0) begin
      errors++; $display("FAIL reset_rdout1 got %h expected 0", {if1.rd_valid, if1.rd_last, if1.rd_data});
    end
    asyn_rst = 0;
    model_clear();
    tick();
  endtask

  task automatic test_basic();
    step0(1, 8'h11, 0, 0, 0);
    step0(1, 8'h22, 0, 0, 0);
    checks++;
    if (if0.empty !== 1'b1) begin errors++; $display("FAIL basic_uncommitted_empty got %b expected 1", if0.empty); end
    step0(1, 8'h33, 1, 0, 0);
    checks++;
    if ({if0.empty, if0.pkt_cnt, if0.rd_cnt} !== {1'b0, 5'd1, 5'd3}) begin
      errors++; $display("FAIL basic_commit got e=%b p=%0d r=%0d expected e=0 p=1 r=3",
        if0.empty, if0.pkt_cnt, if0.rd_cnt);
    end
    checks++;
    if (if0.almost_empty !== 1'b0) begin errors++; $display("FAIL basic_ae_at3 got %b expected 0", if0.almost_empty); end
    step0(0, 0, 0, 0, 1);
    checks++;
    if (if0.almost_empty !== 1'b1) begin errors++; $display("FAIL basic_ae_at2 got %b expected 1", if0.almost_empty); end
    step0(0, 0, 0, 0, 1);
    step0(0, 0, 0, 0, 1);
    checks++;
    if ({if0.pkt_cnt, if0.empty} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL basic_drained got p=%0d e=%b expected p=0 e=1", if0.pkt_cnt, if0.empty);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 5; i++) step0(1, 8'(8'h40 + i), 0, 0, 0);
    checks++;
    if ({if0.wr_cnt, if0.empty} !== {5'd5, 1'b1}) begin
      errors++; $display("FAIL drop_before got w=%0d e=%b expected w=5 e=1", if0.wr_cnt, if0.empty);
    end
    step0(0, 0, 0, 1, 0);
    checks++;
    if ({if0.wr_cnt, if0.empty} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL drop_after got w=%0d e=%b expected w=0 e=1", if0.wr_cnt, if0.empty);
    end
    step0(1, 8'hA0, 0, 0, 0);
    step0(1, 8'hA1, 1, 0, 0);
    checks++;
    if (if0.rd_cnt !== 5'd2) begin errors++; $display("FAIL drop_newpkt got rd_cnt=%0d expected 2", if0.rd_cnt); end
    step0(0, 0, 0, 0, 1);
    step0(0, 0, 0, 0, 1);
  endtask

  task automatic test_oversize();
    int ovf = 0;
    for (int i = 1; i <= 17; i++) begin
      step0(1, 8'(i), 0, 0, 0);
      if (if0.wr_overflow) ovf++;
      if (i == 13 || i == 14) begin
        checks++;
        if (if0.almost_full !== (i == 14)) begin
          errors++; $display("FAIL af_threshold at %0d got %b expected %b", i, if0.almost_full, i == 14);
        end
      end
    end
    checks++;
    if ({if0.wr_cnt, if0.full, if0.almost_full, if0.empty} !== {5'd16, 3'b111}) begin
      errors++; $display("FAIL oversize_full got w=%0d f=%b af=%b e=%b expected 16 1 1 1",
        if0.wr_cnt, if0.full, if0.almost_full, if0.empty);
    end
    checks++;
    if (ovf != 1) begin errors++; $display("FAIL overflow_pulses got %0d expected 1", ovf); end
    step0(1, 8'hEE, 1, 0, 0);
    checks++;
    if ({if0.wr_cnt, if0.full, if0.pkt_cnt, if0.empty} !== {5'd0, 1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL oversize_rollback got w=%0d f=%b p=%0d e=%b expected 0 0 0 1",
        if0.wr_cnt, if0.full, if0.pkt_cnt, if0.empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] w_before, r_before;
    step0(1, 8'h50, 0, 0, 0);
    step0(1, 8'h51, 1, 0, 0);
    step0(1, 8'h60, 0, 0, 1);
    step0(1, 8'h61, 1, 0, 1);
    checks++;
    if (if0.pkt_cnt !== 5'd1) begin errors++; $display("FAIL sim_commit_read got pkt_cnt=%0d expected 1", if0.pkt_cnt); end
    step0(0, 0, 0, 0, 1);
    step0(0, 0, 0, 0, 1);
    w_before = if0.wr_cnt;
    r_before = if0.rd_cnt;
    step0(0, 0, 0, 0, 1);
    checks++;
    if ({if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt, if0.empty} !== {w_before, r_before, 5'd0, 1'b1}
        || w_before !== 5'd0) begin
      errors++; $display("FAIL empty_read got w=%0d r=%0d p=%0d e=%b expected 0 0 0 1",
        if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt, if0.empty);
    end
  endtask

  task automatic test_wrap_outreg();
    logic [8:0] w;
    int widx = 0, got = 0, budget = 0;
    bit acc;
    while (got < 36 && budget < 500) begin
      budget++;
      if (widx < 36 && !if1.full) begin
        if1.wr_en = 1; if1.wr_data = 8'(widx); if1.wr_last = (widx % 3 == 2);
        exp1_q.push_back({if1.wr_last, if1.wr_data});
        widx++;
      end else begin
        if1.wr_en = 0; if1.wr_last = 0;
      end
      acc = !if1.empty;
      if1.rd_en = acc;
      tick();
      if1.wr_en = 0; if1.wr_last = 0; if1.rd_en = 0;
      checks++;
      if (if1.rd_valid !== acc) begin
        errors++; $display("FAIL rd_valid_latency got %b expected %b at word %0d", if1.rd_valid, acc, got);
      end
      if (if1.rd_valid && exp1_q.size() > 0) begin
        w = exp1_q.pop_front();
        got++;
        checks++;
        if ({if1.rd_last, if1.rd_data} !== w) begin
          errors++; $display("FAIL wrap_data got %h expected %h", {if1.rd_last, if1.rd_data}, w);
        end
      end
    end
    checks++;
    if (got != 36) begin errors++; $display("FAIL wrap_count got %0d expected 36", got); end
    tick();
    checks++;
    if ({if1.rd_valid, if1.rd_last, if1.rd_data} !== {1'b0, 1'b1, 8'h23}) begin
      errors++; $display("FAIL outreg_hold got v=%b l=%b d=%h expected 0 1 23",
        if1.rd_valid, if1.rd_last, if1.rd_data);
    end
  endtask

  task automatic test_reset_mid();
    step0(1, 8'h70, 0, 0, 0);
    step0(1, 8'h71, 1, 0, 0);
    step0(1, 8'h80, 0, 0, 0);
    step0(1, 8'h81, 0, 0, 0);
    checks++;
    if ({if0.wr_cnt, if0.pkt_cnt} !== {5'd4, 5'd1}) begin
      errors++; $display("FAIL pre_reset got w=%0d p=%0d expected 4 1", if0.wr_cnt, if0.pkt_cnt);
    end
    #2 asyn_rst = 1;
    #1;
    checks++;
    if ({if0.empty, if0.almost_empty, if0.full, if0.almost_full, if0.wr_overflow,
         if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt} !== {5'b11000, 15'd0}) begin
      errors++; $display("FAIL async_reset0 got e=%b w=%0d r=%0d p=%0d", if0.empty,
        if0.wr_cnt, if0.rd_cnt, if0.pkt_cnt);
    end
    checks++;
    if ({if1.rd_valid, if1.rd_last, if1.rd_data} !== 10'd0) begin
      errors++; $display("FAIL async_reset1 got %h expected 0", {if1.rd_valid, if1.rd_last, if1.rd_data});
    end
    #1 asyn_rst = 0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    if0.wr_en = 0; if0.wr_data = 0; if0.wr_last = 0; if0.wr_drop = 0; if0.rd_en = 0;
    if1.wr_en = 0; if1.wr_data = 0; if1.wr_last = 0; if1.wr_drop = 0; if1.rd_en = 0;
    test_reset();
    test_basic();
    test_drop();
    test_oversize();
    test_simultaneous();
    test_wrap_outreg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
